// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 mux select with lock/burst support.
// Optional MUX_ARB_HOLD_LIMIT_EN: a locked grant yields to a waiting requester after HOLD_MAX cycles.
module mux_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_0,
    input  logic req_1,
    input  logic lock_0,
    input  logic lock_1,
    input  logic done,
    output logic grant_0,
    output logic grant_1,
    output logic sel,
    output logic busy
);

    // state | meaning
    // IDLE  | no grant active, arbitrating between pending requests
    // G0    | requester 0 owns the resource (sel=0)
    // G1    | requester 1 owns the resource (sel=1)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_e;

`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_SAT   = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             grant_0_q, grant_0_d;
    logic             grant_1_q, grant_1_d;
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;

    logic own_id;
    logic own_req;
    logic own_lock;
    logic oth_req;
    logic force_rel;
    logic release_x;
    logic new_grant;

    // Requests seen from the current owner's point of view.
    always_comb begin
        own_id    = (state_q == G1);
        own_req   = own_id ? req_1  : req_0;
        own_lock  = own_id ? lock_1 : lock_0;
        oth_req   = own_id ? req_0  : req_1;
        force_rel = LIMIT_EN && own_lock && oth_req && (hold_q >= HOLD_MAX_C);
        // done with req dropped counts as a release even when locked
        release_x = done && (!own_lock || !own_req || force_rel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_0 && req_1) begin
                    state_d   = last_q ? G0 : G1;
                    new_grant = 1'b1;
                end else if (req_0) begin
                    state_d   = G0;
                    new_grant = 1'b1;
                end else if (req_1) begin
                    state_d   = G1;
                    new_grant = 1'b1;
                end
            end
            G0, G1: begin
                if (release_x) begin
                    last_d = own_id;
                    if (oth_req) begin
                        state_d   = own_id ? G0 : G1;
                        new_grant = 1'b1;
                    end else if (own_req) begin
                        state_d   = state_q;
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!own_req) begin
                    state_d = IDLE;
                    last_d  = own_id;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Cycles spent in the current grant; a re-grant after release starts a fresh count.
    always_comb begin
        hold_d = hold_q;
        if (new_grant || state_d == IDLE) begin
            hold_d = '0;
        end else if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + CNT_W'(1);
        end
    end

    always_comb begin
        grant_0_d = (state_d == G0);
        grant_1_d = (state_d == G1);
        sel_d     = (state_d == G1);
        busy_d    = (state_d == G0) || (state_d == G1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_0_q <= 1'b0;
            grant_1_q <= 1'b0;
            sel_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            grant_0_q <= grant_0_d;
            grant_1_q <= grant_1_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
        end
    end

    assign grant_0 = grant_0_q;
    assign grant_1 = grant_1_q;
    assign sel     = sel_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios followed by random traffic against an ownership model.
module tb_mux_arbiter;

    localparam int HOLD_MAX = 16;
    localparam int CNT_W    = 5;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic req_0, req_1, lock_0, lock_1, done;
    logic grant_0, grant_1, sel, busy;

    int vec_cnt;
    int err_cnt;

    // Reference model: who owns the port (-1 none), who was served last, cycles in grant.
    int owner;
    int last;
    int cycles;

    mux_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_0   (req_0),
        .req_1   (req_1),
        .lock_0  (lock_0),
        .lock_1  (lock_1),
        .done    (done),
        .grant_0 (grant_0),
        .grant_1 (grant_1),
        .sel     (sel),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] expected_outs();
        logic [3:0] e;
        e[3] = (owner == 0);
        e[2] = (owner == 1);
        e[1] = (owner == 1);
        e[0] = (owner != -1);
        return e;
    endfunction

    task automatic check(input string tag);
        logic [3:0] obs;
        logic [3:0] exp_v;
        obs   = {grant_0, grant_1, sel, busy};
        exp_v = expected_outs();
        vec_cnt++;
        assert (obs === exp_v)
        else begin
            err_cnt++;
            $error("FAIL %s: {g0,g1,sel,busy} observed=%b expected=%b (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_edge();
        int  x, o;
        bit  rq[2];
        bit  lk[2];
        bit  forced;
        rq[0] = req_0; rq[1] = req_1;
        lk[0] = lock_0; lk[1] = lock_1;
        if (owner == -1) begin
            if (rq[0] && rq[1]) owner = 1 - last;
            else if (rq[0])     owner = 0;
            else if (rq[1])     owner = 1;
            cycles = 0;
        end else begin
            x = owner;
            o = 1 - owner;
            forced = HOLD_EN && lk[x] && rq[o] && (cycles >= HOLD_MAX);
            if (done && (!lk[x] || !rq[x] || forced)) begin
                last = x;
                if (rq[o])      owner = o;
                else if (rq[x]) owner = x;
                else            owner = -1;
                cycles = 0;
            end else if (!rq[x]) begin
                last   = x;
                owner  = -1;
                cycles = 0;
            end else begin
                cycles = (cycles < (1 << CNT_W) - 1) ? cycles + 1 : cycles;
            end
        end
    endtask

    task automatic step(input bit r0, input bit r1, input bit l0, input bit l1, input bit d,
                        input string tag);
        req_0 = r0; req_1 = r1; lock_0 = l0; lock_1 = l1; done = d;
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic do_reset();
        req_0 = 0; req_1 = 0; lock_0 = 0; lock_1 = 0; done = 0;
        rst_n = 1'b0;
        owner = -1; last = 1; cycles = 0;
        #1;
        check("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        req_0 = 0; req_1 = 0; lock_0 = 0; lock_1 = 0; done = 0;
        rst_n = 1'b0;
        owner = -1; last = 1; cycles = 0;
        #12;
        check("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // First tie goes to requester 0.
        step(1, 1, 0, 0, 0, "tie_first");
        // Round-robin: done every 3rd cycle, grants alternate without idle.
        for (int i = 0; i < 12; i++)
            step(1, 1, 0, 0, (i % 3) == 2, "round_robin");

        // Single requester with re-grant, then drop at the next done.
        step(0, 0, 0, 0, 1, "rr_drain");
        step(0, 0, 0, 0, 0, "idle");
        step(0, 0, 0, 0, 1, "done_in_idle");
        for (int i = 0; i < 5; i++)
            step(0, 1, 0, 0, i == 3, "single_regrant");
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 0, 0, "single_hold");
        step(0, 0, 0, 0, 1, "single_release");
        step(0, 0, 0, 0, 0, "single_idle");

        // Cancel with a pending other request.
        step(1, 0, 0, 0, 0, "cancel_grant0");
        step(1, 1, 0, 0, 0, "cancel_hold");
        step(0, 1, 0, 0, 0, "cancel_drop");
        step(0, 1, 0, 0, 0, "cancel_then_g1");
        step(0, 0, 0, 0, 1, "cancel_cleanup");

        // Lock: requester 1 holds through five dones, yields on the sixth.
        step(0, 1, 0, 1, 0, "lock_grant1");
        for (int i = 0; i < 10; i++)
            step(1, 1, 0, 1, i[0], "lock_held");
        step(1, 1, 0, 0, 1, "lock_release");
        step(1, 1, 0, 0, 0, "lock_to_g0");

        // Long lock on requester 0 with requester 1 waiting: hold limit only with the macro.
        for (int i = 0; i < 24; i++)
            step(1, 1, 1, 0, 1, "hold_limit");
        step(0, 0, 0, 0, 1, "hold_cleanup");
        step(0, 0, 0, 0, 0, "hold_idle");

        // Asynchronous reset mid-grant, then a tie after reset goes to requester 0.
        step(0, 1, 0, 0, 0, "pre_reset_g1");
        #2;
        do_reset();
        step(1, 1, 0, 0, 0, "post_reset_tie");

        // Random traffic.
        begin
            bit r0, r1;
            r0 = 0; r1 = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(7) == 0) r0 = ~r0;
                if ($urandom_range(7) == 0) r1 = ~r1;
                step(r0, r1, $urandom_range(3) == 0, $urandom_range(3) == 0,
                     $urandom_range(2) == 0, "random");
                if (i == 1500) begin
                    #3;
                    do_reset();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
